// File: rtl/envelope_pkg.sv
// ============================================================================
// Module      : envelope_pkg
// Description : Shared state encoding and default constants for the envelope
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package envelope_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam int          CNT_W_DEF    = 24;
    localparam int          MAX_SHIFT    = 8;
    localparam logic [23:0] ATTACK_DEF   = 24'h2625A0;
    localparam logic [23:0] RELEASE_DEF  = 24'h969680;
    localparam logic [23:0] HOLD_MAX_DEF = 24'hFFFFFF;

endpackage : envelope_pkg

`default_nettype wire

// File: rtl/envelope_sequencer_if.sv
// ============================================================================
// Module      : envelope_sequencer_if
// Description : Valid/ready configuration port carrying the attack and
//               release step periods.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface envelope_sequencer_if #(
    parameter int CNT_W = 24
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_attack;
    logic [CNT_W-1:0] cfg_release;

    modport master (
        output cfg_valid,
        output cfg_attack,
        output cfg_release,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_attack,
        input  cfg_release,
        output cfg_ready
    );
endinterface : envelope_sequencer_if

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/envelope_sequencer.sv
// ============================================================================
// Module      : envelope_sequencer
// Description : IDLE/ATTACK/SUSTAIN/RELEASE envelope driving the sample
//               attenuation shift. Optional macro SUSTAIN_TIMEOUT_EN adds a
//               sustain hold limit (HOLD_MAX cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module envelope_sequencer
    import envelope_pkg::*;
#(
    parameter int               CNT_W       = envelope_pkg::CNT_W_DEF,
    parameter int               MAX_SHIFT   = envelope_pkg::MAX_SHIFT,
    parameter logic [CNT_W-1:0] ATTACK_DEF  = CNT_W'(envelope_pkg::ATTACK_DEF),
    parameter logic [CNT_W-1:0] RELEASE_DEF = CNT_W'(envelope_pkg::RELEASE_DEF),
    parameter logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(envelope_pkg::HOLD_MAX_DEF)
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    input  wire logic           key_on,
    envelope_sequencer_if.slave cfg,
    output logic [3:0]          shift,
    output logic                gate,
    output logic [1:0]          state
);

    localparam logic [3:0]       c_MAX_SHIFT = 4'(MAX_SHIFT);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    function automatic logic [CNT_W-1:0] f_period(input logic [CNT_W-1:0] p);
        return (p == '0) ? c_ONE : p;
    endfunction

    logic             w_key_s;
    logic             r_key_prev;
    logic             w_rise;
    logic             w_fall;
    logic             w_cfg_wr;
    logic             w_att_step;
    logic             w_rel_step;
    logic             w_hold_done;
    logic [CNT_W-1:0] r_attack_per;
    logic [CNT_W-1:0] r_release_per;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_shift;
    env_state_t       r_state;
    logic             r_gate;
    logic             r_cfg_ready;

    sync_2ff u_key_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .i_d   (key_on),
        .o_q   (w_key_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_prev <= 1'b0;
        end else begin
            r_key_prev <= w_key_s;
        end
    end

    assign w_rise     = w_key_s & ~r_key_prev;
    assign w_fall     = ~w_key_s & r_key_prev;
    assign w_cfg_wr   = cfg.cfg_valid & r_cfg_ready;
    assign w_att_step = (r_cnt == r_attack_per - c_ONE);
    assign w_rel_step = (r_cnt == r_release_per - c_ONE);

    // Periods land on the same edge that may leave IDLE, so ATTACK sees them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_attack_per  <= ATTACK_DEF;
            r_release_per <= RELEASE_DEF;
        end else if (w_cfg_wr) begin
            r_attack_per  <= f_period(cfg.cfg_attack);
            r_release_per <= f_period(cfg.cfg_release);
        end
    end

`ifdef SUSTAIN_TIMEOUT_EN
    logic [CNT_W-1:0] r_hold_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
        end else if (r_state == SUSTAIN) begin
            r_hold_cnt <= r_hold_cnt + c_ONE;
        end else begin
            r_hold_cnt <= '0;
        end
    end

    assign w_hold_done = (r_state == SUSTAIN) && (r_hold_cnt == HOLD_MAX - c_ONE);
`else
    assign w_hold_done = 1'b0;

    // HOLD_MAX has no effect unless the sustain timeout is built in.
    if (HOLD_MAX == '0) begin : g_hold_unused
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shift     <= c_MAX_SHIFT;
            r_cnt       <= '0;
            r_gate      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_shift <= c_MAX_SHIFT;
                    if (w_rise) begin
                        r_state     <= ATTACK;
                        r_cnt       <= '0;
                        r_gate      <= 1'b1;
                        r_cfg_ready <= 1'b0;
                    end
                end
                ATTACK: begin
                    if (w_fall) begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                    end else if (r_shift == 4'd0) begin
                        r_state <= SUSTAIN;
                        r_cnt   <= '0;
                    end else if (w_att_step) begin
                        r_cnt   <= '0;
                        r_shift <= r_shift - 4'd1;
                        if (r_shift == 4'd1) begin
                            r_state <= SUSTAIN;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                SUSTAIN: begin
                    r_shift <= 4'd0;
                    if (w_fall || w_hold_done) begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                    end
                end
                RELEASE: begin
                    // Retrigger outranks a release step landing on the same edge.
                    if (w_rise) begin
                        r_state <= ATTACK;
                        r_cnt   <= '0;
                    end else if (r_shift >= c_MAX_SHIFT) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_gate      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else if (w_rel_step) begin
                        r_cnt   <= '0;
                        r_shift <= r_shift + 4'd1;
                        if (r_shift == c_MAX_SHIFT - 4'd1) begin
                            r_state     <= IDLE;
                            r_gate      <= 1'b0;
                            r_cfg_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_shift     <= c_MAX_SHIFT;
                    r_cnt       <= '0;
                    r_gate      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = r_cfg_ready;
    assign shift         = r_shift;
    assign gate          = r_gate;
    assign state         = r_state;

endmodule : envelope_sequencer

`default_nettype wire

// File: doc/envelope_sequencer.md
Name: envelope_sequencer

Overview:
- Controls the attenuator stage of the digital keyboard. Runs a four-state envelope: IDLE, ATTACK, SUSTAIN, RELEASE.
- Drives the shift amount applied to each 8-bit sample from the SPI receiver. Gates silence between notes.
- Step periods are runtime-configurable through a valid/ready port. They are fixed while a note is sounding.

Parameters:
- CNT_W, 24: width of the step-period counter and of the config period fields.
- MAX_SHIFT, 8: shift value that means full silence. Envelope range is 0..MAX_SHIFT.
- ATTACK_DEF, 24'h2625A0: reset value of the attack step period, in clk cycles per shift step.
- RELEASE_DEF, 24'h969680: reset value of the release step period, in clk cycles per shift step.
- HOLD_MAX, 24'hFFFFFF: sustain cycle limit. Used only with SUSTAIN_TIMEOUT_EN.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- key_on, input, 1: key held, asynchronous to clk. Synchronised internally.
- cfg_valid, input, 1: a configuration write is offered.
- cfg_ready, output, 1: configuration can be accepted. High only in IDLE.
- cfg_attack, input, CNT_W: new attack step period.
- cfg_release, input, CNT_W: new release step period.
- shift, output, 4: attenuation shift amount for the datapath (sample >> shift).
- gate, output, 1: high when the state is not IDLE.
- state, output, 2: current state encoding, for debug.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, shift=MAX_SHIFT, gate=0, cfg_ready=1.
  - Counter cleared. Period registers set to ATTACK_DEF and RELEASE_DEF.
  - Synchroniser flops cleared.
- key_on passes through a 2-flop synchroniser, giving key_s. Rise and fall are detected on key_s vs its previous value.
  - A raw edge is seen by the FSM 3 cycles later.
- Config handshake: a write happens when cfg_valid && cfg_ready, on a clock edge.
  - A period value of 0 is stored as 1.
  - If a key rise and a config write occur in the same cycle, the write is accepted first. ATTACK then uses the new values.
- IDLE:
  - shift=MAX_SHIFT.
  - On key rise: go to ATTACK, clear the counter.
- ATTACK:
  - The counter increments each cycle.
  - When counter == attack_period-1: counter clears and shift decrements.
  - When shift reaches 0: go to SUSTAIN.
  - If key_s falls first: go to RELEASE with shift kept and the counter cleared.
- SUSTAIN:
  - shift=0.
  - On key_s fall: go to RELEASE, clear the counter.
- RELEASE:
  - The counter increments each cycle.
  - When counter == release_period-1: counter clears and shift increments.
  - When shift reaches MAX_SHIFT: go to IDLE.
  - On key rise (retrigger): go to ATTACK from the current shift, counter cleared.
- The shift value is saturating and never leaves 0..MAX_SHIFT. No wrap-around.
- Full attack from MAX_SHIFT takes MAX_SHIFT*attack_period cycles. Release is the same with release_period.
- A key rise and fall within one synchronised cycle pair is not seen and causes no action.
- A reset asserted mid-note forces IDLE immediately. shift returns to MAX_SHIFT asynchronously.

Optional Feature:
- Macro: SUSTAIN_TIMEOUT_EN.
- Defined: a hold counter (CNT_W bits) runs in SUSTAIN. When it reaches HOLD_MAX-1, the FSM goes to RELEASE even if key_s is still high.
  - A new key rise is then needed to retrigger.
  - The hold counter clears on entering SUSTAIN.
- Undefined: SUSTAIN lasts until key_s falls. No hold counter is built.

Decomposition:
- Package envelope_pkg holds:
  - typedef enum logic [1:0] env_state_t: IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3.
  - MAX_SHIFT as a localparam.
  - The default period constants.
- One sub-module, sync_2ff: a 2-flop synchroniser with async active-low reset, used for key_on.
- The FSM, step counter and config registers stay in envelope_sequencer.

Test Plan:
- Reset behaviour:
  - Stimulus: reset_n=0 mid-ATTACK, then released.
  - Required: shift=8, gate=0, state=0 immediately. No state change until the next key rise.
- Full envelope:
  - Stimulus: cfg_attack=4, cfg_release=2. key_on held for 100 cycles, then dropped.
  - Required: shift steps 8→0 at 4-cycle spacing (32 cycles after the sync delay). SUSTAIN at shift=0. Then 0→8 at 2-cycle spacing, ending in IDLE with gate=0.
- Early release:
  - Stimulus: attack=4. Drop key_on when shift=5.
  - Required: RELEASE begins at shift=5 and climbs to 8. No entry into SUSTAIN.
- Retrigger:
  - Stimulus: raise key_on during RELEASE at shift=6.
  - Required: ATTACK resumes from 6 and reaches 0 after 6*attack_period cycles.
- Config gating:
  - Stimulus: cfg_valid in SUSTAIN, then in IDLE, with cfg_attack=0.
  - Required: cfg_ready=0 and no write in SUSTAIN. Write accepted in IDLE, stored period=1, next attack steps every cycle.
- Timeout (SUSTAIN_TIMEOUT_EN, HOLD_MAX=10):
  - Stimulus: key_on held indefinitely.
  - Required: RELEASE is entered 10 cycles after SUSTAIN entry and the FSM returns to IDLE.
